// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// The master requests conversions; the converter sits on the slave side.
interface bin_to_bcd_seq_if #(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = 8
);
  logic                  start;
  logic [BIN_WIDTH-1:0]  bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  overflow
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, saturating BCD
// result with a sticky overflow when the operand needs more than DIGITS digits.
//
//   state | meaning
//   IDLE  | waiting for start; result registers hold the last conversion
//   SHIFT | add-3 and shift, one operand bit per cycle, BIN_WIDTH cycles
//   DONE  | one-cycle done pulse; new start is accepted here as well
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  bin_to_bcd_seq_if.slave   bus
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [BIN_WIDTH-1:0]  sr_q, sr_d;
  logic [SCR_W-1:0]      scr_q, scr_d;
  logic                  sticky_q, sticky_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SCR_W-1:0]      bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;

  logic [SCR_W-1:0]      adj;
  logic [SCR_W-1:0]      scr_shift;
  logic [BIN_WIDTH-1:0]  sr_shift;
  logic                  carry_out;
  logic                  sticky_next;

  // Per-digit add-3 correction applied before every shift
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign carry_out   = adj[SCR_W-1];
  assign scr_shift   = {adj[SCR_W-2:0], sr_q[BIN_WIDTH-1]};
  assign sr_shift    = {sr_q[BIN_WIDTH-2:0], 1'b0};
  assign sticky_next = sticky_q | carry_out;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    scr_d    = scr_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          sr_d     = bus.bin;
          scr_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        sr_d     = sr_shift;
        scr_d    = scr_shift;
        sticky_d = sticky_next;
        cnt_d    = cnt_q + CNT_ONE;
        // Result registers load on the same edge that enters DONE
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          ovf_d   = sticky_next;
          bcd_d   = sticky_next ? {DIGITS{4'h9}} : scr_shift;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      scr_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      scr_q    <= scr_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = (state_q == DONE);
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule
